// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream reader.
package fifo_pkg;

    localparam int unsigned READER_BUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready output buffer; entry0 is the head and drives the stream data.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DWidth = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DWidth-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DWidth-1:0] data_o,
    output logic              valid_o,
    output buf_cnt_t          count_o
);

    logic [DWidth-1:0] entry0_q, entry0_d;
    logic [DWidth-1:0] entry1_q, entry1_d;
    buf_cnt_t          cnt_q, cnt_d;
    logic              pop;

    assign pop = pop_i & (cnt_q != '0);

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        cnt_d    = cnt_q;
        case ({push_i, pop})
            2'b01: begin
                entry0_d = entry1_q;
                cnt_d    = cnt_q - 2'd1;
            end
            2'b10: begin
                if (cnt_q == '0) begin
                    entry0_d = push_data_i;
                end else begin
                    entry1_d = push_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new word lands behind whatever shifts into the head.
                if (cnt_q == 2'd1) begin
                    entry0_d = push_data_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry0_q <= '0;
            entry1_q <= '0;
            cnt_q    <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            cnt_q    <= cnt_d;
        end
    end

    assign data_o  = entry0_q;
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

    overrun_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_i && !pop && (cnt_q == buf_cnt_t'(READER_BUF_DEPTH))));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO, presenting a valid/ready stream.
// Optional packet framing (m_last) is enabled with FIFO_READER_LAST_EN.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned PKT_LEN = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
`ifdef FIFO_READER_LAST_EN
   ,output logic              m_last
`endif
);

    if (PKT_LEN < 1) begin : g_bad_pkt_len
        $error("PKT_LEN must be at least 1");
    end

    logic     inflight_q;
    buf_cnt_t cnt;
    logic     pop;
    logic [2:0] occ;

    assign pop = m_valid & m_ready;

    // Credit check: buffered plus in-flight words after this cycle's pop must leave a free slot.
    always_comb begin
        occ        = {1'b0, cnt} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = ~fifo_empty & (occ < 3'(READER_BUF_DEPTH));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd_en;
        end
    end

    stream_skid_buf #(
        .DWidth (DWIDTH)
    ) u_buf (
        .clk_i       (clk),
        .rst_ni      (rstn),
        .push_i      (inflight_q),
        .push_data_i (fifo_dout),
        .pop_i       (m_ready),
        .data_o      (m_data),
        .valid_o     (m_valid),
        .count_o     (cnt)
    );

`ifdef FIFO_READER_LAST_EN
    localparam int unsigned BeatW = $clog2(PKT_LEN + 1);
    localparam logic [BeatW-1:0] LastIdx = BeatW'(PKT_LEN - 1);

    logic [BeatW-1:0] beat_q, beat_d;

    always_comb begin
        beat_d = beat_q;
        if (pop) begin
            beat_d = (beat_q == LastIdx) ? '0 : beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign m_last = m_valid & (beat_q == LastIdx);
`endif

endmodule
